// File: rtl/pifarb_if.sv
// -----------------------------------------------------------------------------
// pifarb_if
// Signal bundle between the two PIF requesters, the pifarb arbiter and the
// pifctl register bus.
//   master : arbiter view. Takes requests and XO; drives acks, rdata and XI_*.
//   slave  : environment view. Requesters and pifctl.
// Requester side (x = a | b):
//   x_req, x_we, x_addr[AW], x_suba[SW], x_wdata[DW] -> arbiter
//   x_ack, x_rdata[8]                                <- arbiter
// pifctl side:
//   XI_PWr, XI_PRWA[AW], XI_PRdSubA[SW], XI_PD[DW], XI_PRdFinished <- arbiter
//   XO[8]                                                          -> arbiter
// -----------------------------------------------------------------------------
interface pifarb_if #(
   parameter int AW = 8,
   parameter int SW = 4,
   parameter int DW = 8
);
   logic          a_req;
   logic          b_req;
   logic          a_we;
   logic          b_we;
   logic [AW-1:0] a_addr;
   logic [AW-1:0] b_addr;
   logic [SW-1:0] a_suba;
   logic [SW-1:0] b_suba;
   logic [DW-1:0] a_wdata;
   logic [DW-1:0] b_wdata;
   logic          a_ack;
   logic          b_ack;
   logic [7:0]    a_rdata;
   logic [7:0]    b_rdata;
   logic          XI_PWr;
   logic [AW-1:0] XI_PRWA;
   logic [SW-1:0] XI_PRdSubA;
   logic [DW-1:0] XI_PD;
   logic          XI_PRdFinished;
   logic [7:0]    XO;

   modport master (
      input  a_req, b_req, a_we, b_we, a_addr, b_addr, a_suba, b_suba,
             a_wdata, b_wdata, XO,
      output a_ack, b_ack, a_rdata, b_rdata, XI_PWr, XI_PRWA, XI_PRdSubA,
             XI_PD, XI_PRdFinished
   );

   modport slave (
      output a_req, b_req, a_we, b_we, a_addr, b_addr, a_suba, b_suba,
             a_wdata, b_wdata, XO,
      input  a_ack, b_ack, a_rdata, b_rdata, XI_PWr, XI_PRWA, XI_PRdSubA,
             XI_PD, XI_PRdFinished
   );
endinterface

// File: rtl/pifarb.sv
// -----------------------------------------------------------------------------
// pifarb
// Two-port arbiter / sequencer for the PIF register bus feeding pifctl.
// Port A (I2C slave front end) and port B (auxiliary host) each issue single
// register reads or writes; one is granted at a time. Writes produce a
// one-cycle XI_PWr strobe; reads hold the address for READ_LAT+1 cycles,
// capture XO and return it on the port's rdata with a one-cycle ack.
//
// Parameters: AW (address width), SW (read sub-address width), DW (write
//             data width), READ_LAT (address-to-XO latency, 1..15).
// Ports:
//   xclk     clock
//   sys_rst  asynchronous, active-low reset
//   bus      pifarb_if.master: requester handshakes, rdata, XI_* bus, XO
//
// Build option: define PIFARB_RR_EN for round-robin tie breaking (the port
// not granted last wins; pointer resets to B). Without it, A always wins a
// tie and no pointer register exists.
// -----------------------------------------------------------------------------
module pifarb #(
   parameter int AW       = 8,
   parameter int SW       = 4,
   parameter int DW       = 8,
   parameter int READ_LAT = 5
) (
   input  logic     xclk,
   input  logic     sys_rst,
   pifarb_if.master bus
);

   typedef enum logic [1:0] {IDLE, WR, RD, ACK} state_t;

   localparam logic [3:0] LAT    = 4'(READ_LAT);
   localparam logic       PORT_A = 1'b0;
   localparam logic       PORT_B = 1'b1;

   state_t        state_reg, state_next;
   logic [3:0]    cnt_reg, cnt_next;
   logic          gnt_reg, gnt_next;
   logic          pwr_reg, pwr_next;
   logic          fin_reg, fin_next;
   logic [1:0]    ack_reg, ack_next;
   logic [1:0]    capture;
   // The XI_* address/data registers double as the latched command: they
   // are loaded only on grant, so requester changes after grant are ignored.
   logic [AW-1:0] prwa_reg, prwa_next;
   logic [SW-1:0] suba_reg, suba_next;
   logic [DW-1:0] pd_reg, pd_next;

   logic [1:0]    req;
   logic          winner;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [SW-1:0] sel_suba;
   logic [DW-1:0] sel_wdata;

   assign req = {bus.b_req, bus.a_req};

`ifdef PIFARB_RR_EN
   logic ptr_reg, ptr_next;
`endif

   // Winner selection for the IDLE cycle
   always_comb begin
      winner = PORT_A;
      if (req == 2'b10) begin
         winner = PORT_B;
      end else if (req == 2'b11) begin
`ifdef PIFARB_RR_EN
         winner = (ptr_reg == PORT_B) ? PORT_A : PORT_B;
`else
         winner = PORT_A;
`endif
      end
   end

   assign sel_we    = (winner == PORT_B) ? bus.b_we    : bus.a_we;
   assign sel_addr  = (winner == PORT_B) ? bus.b_addr  : bus.a_addr;
   assign sel_suba  = (winner == PORT_B) ? bus.b_suba  : bus.a_suba;
   assign sel_wdata = (winner == PORT_B) ? bus.b_wdata : bus.a_wdata;

   // Next-state and registered-output logic
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      gnt_next   = gnt_reg;
      pwr_next   = 1'b0;
      fin_next   = 1'b0;
      ack_next   = 2'b00;
      capture    = 2'b00;
      prwa_next  = prwa_reg;
      suba_next  = suba_reg;
      pd_next    = pd_reg;
`ifdef PIFARB_RR_EN
      ptr_next   = ptr_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (|req) begin
               gnt_next  = winner;
`ifdef PIFARB_RR_EN
               ptr_next  = winner;
`endif
               prwa_next = sel_addr;
               if (sel_we) begin
                  state_next = WR;
                  pwr_next   = 1'b1;
                  pd_next    = sel_wdata;
               end else begin
                  state_next = RD;
                  suba_next  = sel_suba;
                  cnt_next   = 4'd0;
               end
            end
         end
         WR: begin
            state_next        = ACK;
            ack_next[gnt_reg] = 1'b1;
         end
         RD: begin
            // Compare happens before the counter can overflow (LAT <= 15)
            if (cnt_reg == LAT) begin
               state_next        = ACK;
               ack_next[gnt_reg] = 1'b1;
               capture[gnt_reg]  = 1'b1;
               fin_next          = 1'b1;
            end else begin
               cnt_next = cnt_reg + 4'd1;
            end
         end
         ACK: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge xclk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
         gnt_reg   <= PORT_A;
         pwr_reg   <= 1'b0;
         fin_reg   <= 1'b0;
         ack_reg   <= 2'b00;
         prwa_reg  <= '0;
         suba_reg  <= '0;
         pd_reg    <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         gnt_reg   <= gnt_next;
         pwr_reg   <= pwr_next;
         fin_reg   <= fin_next;
         ack_reg   <= ack_next;
         prwa_reg  <= prwa_next;
         suba_reg  <= suba_next;
         pd_reg    <= pd_next;
      end
   end

`ifdef PIFARB_RR_EN
   always_ff @(posedge xclk or negedge sys_rst) begin
      if (!sys_rst) begin
         ptr_reg <= PORT_B;
      end else begin
         ptr_reg <= ptr_next;
      end
   end
`endif

   // Per-port read data, held until that port's next read completes
   for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic [7:0] rdata_reg;
      always_ff @(posedge xclk or negedge sys_rst) begin
         if (!sys_rst) begin
            rdata_reg <= 8'h00;
         end else if (capture[gi]) begin
            rdata_reg <= bus.XO;
         end
      end
   end

   assign bus.a_ack          = ack_reg[0];
   assign bus.b_ack          = ack_reg[1];
   assign bus.a_rdata        = g_port[0].rdata_reg;
   assign bus.b_rdata        = g_port[1].rdata_reg;
   assign bus.XI_PWr         = pwr_reg;
   assign bus.XI_PRWA        = prwa_reg;
   assign bus.XI_PRdSubA     = suba_reg;
   assign bus.XI_PD          = pd_reg;
   assign bus.XI_PRdFinished = fin_reg;

endmodule

// File: tb/tb_pifarb.sv
// -----------------------------------------------------------------------------
// tb_pifarb
// Self-checking bench for pifarb. A small pifctl model answers reads on XO
// READ_LAT cycles after the address appears and keeps a scratch register.
// Expected read data is queued when a request is driven and popped on ack.
// -----------------------------------------------------------------------------
module tb_pifarb;
   localparam int AW = 8;
   localparam int SW = 4;
   localparam int DW = 8;
   localparam int RL = 5;

   localparam logic [7:0] W_SCRATCH_REG = 8'h10;
   localparam logic [7:0] R_ID          = 8'h01;
   localparam logic [3:0] SUBA_ID       = 4'h0;
   localparam logic [3:0] SUBA_SCR      = 4'h3;

   typedef struct packed {
      logic       port;
      logic [7:0] data;
   } exp_t;

   logic xclk    = 1'b0;
   logic sys_rst = 1'b0;
   always #5 xclk = ~xclk;

   pifarb_if #(.AW(AW), .SW(SW), .DW(DW)) bus ();

   pifarb #(.AW(AW), .SW(SW), .DW(DW), .READ_LAT(RL)) dut (
      .xclk    (xclk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   int         n_vec = 0;
   int         n_err = 0;
   exp_t       sb[$];
   logic [7:0] exp_scratch = 8'h00;
   logic [7:0] exp_rdata [2];

   // pifctl register map model
   function automatic logic [7:0] pif_read(input logic [7:0] addr,
                                           input logic [3:0] suba,
                                           input logic [7:0] scr);
      if (addr == R_ID && suba == SUBA_ID)  return 8'hA5;
      if (addr == R_ID && suba == SUBA_SCR) return scr ^ 8'h40;
      return addr ^ {suba, suba} ^ 8'h5C;
   endfunction

   logic [7:0] pif_scratch = 8'h00;
   logic [7:0] xo_pipe [RL];

   always @(posedge xclk) begin
      if (bus.XI_PWr && bus.XI_PRWA == W_SCRATCH_REG) pif_scratch <= bus.XI_PD;
      xo_pipe[0] <= pif_read(bus.XI_PRWA, bus.XI_PRdSubA, pif_scratch);
      for (int i = 1; i < RL; i++) xo_pipe[i] <= xo_pipe[i-1];
   end
   assign bus.XO = xo_pipe[RL-1];

   task automatic clear_inputs();
      bus.a_req = 1'b0; bus.b_req = 1'b0;
      bus.a_we = 1'b0; bus.b_we = 1'b0;
      bus.a_addr = '0; bus.b_addr = '0;
      bus.a_suba = '0; bus.b_suba = '0;
      bus.a_wdata = '0; bus.b_wdata = '0;
   endtask

   task automatic test_reset();
      sys_rst = 1'b0;
      exp_rdata[0] = 8'h00;
      exp_rdata[1] = 8'h00;
      repeat (3) @(posedge xclk);
      @(negedge xclk);
      n_vec++;
      if ({bus.a_ack, bus.b_ack, bus.XI_PWr, bus.XI_PRdFinished} !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_strobes got %b required 0000",
                  {bus.a_ack, bus.b_ack, bus.XI_PWr, bus.XI_PRdFinished});
      end
      n_vec++;
      if ({bus.XI_PRWA, bus.XI_PRdSubA, bus.XI_PD} !== 20'h0) begin
         n_err++;
         $display("FAIL reset_bus got prwa=%h suba=%h pd=%h required 0",
                  bus.XI_PRWA, bus.XI_PRdSubA, bus.XI_PD);
      end
      n_vec++;
      if ({bus.a_rdata, bus.b_rdata} !== 16'h0) begin
         n_err++;
         $display("FAIL reset_rdata got a=%h b=%h required 0", bus.a_rdata, bus.b_rdata);
      end
      @(posedge xclk); #1;
      sys_rst = 1'b1;
      $display("txn reset released");
   endtask

   task automatic test_write();
      bus.a_req = 1'b1; bus.a_we = 1'b1;
      bus.a_addr = W_SCRATCH_REG; bus.a_wdata = 8'h2A;
      exp_scratch = 8'h2A;
      for (int c = 0; c <= 3; c++) begin
         @(negedge xclk);
         n_vec++;
         if (bus.XI_PWr !== (c == 1) || bus.a_ack !== (c == 2) || bus.b_ack !== 1'b0) begin
            n_err++;
            $display("FAIL wr_a cycle %0d got pwr=%b a_ack=%b b_ack=%b required pwr=%b a_ack=%b b_ack=0",
                     c, bus.XI_PWr, bus.a_ack, bus.b_ack, c == 1, c == 2);
         end
         if (c == 1) begin
            n_vec++;
            if (bus.XI_PD !== 8'h2A || bus.XI_PRWA !== W_SCRATCH_REG) begin
               n_err++;
               $display("FAIL wr_a_bus got addr=%h data=%h required addr=%h data=2a",
                        bus.XI_PRWA, bus.XI_PD, W_SCRATCH_REG);
            end
         end
         @(posedge xclk); #1;
         if (c == 2) bus.a_req = 1'b0;
      end
      $display("txn A write addr=%h data=2a", W_SCRATCH_REG);
   endtask

   task automatic do_read(input logic port, input logic [7:0] addr, input logic [3:0] suba);
      exp_t       e;
      logic       ack_p, ack_o;
      logic [7:0] rd_p, rd_o;
      e.port = port;
      e.data = pif_read(addr, suba, exp_scratch);
      sb.push_back(e);
      if (port) begin
         bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = addr; bus.b_suba = suba;
      end else begin
         bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = addr; bus.a_suba = suba;
      end
      for (int c = 0; c <= RL + 3; c++) begin
         @(negedge xclk);
         ack_p = port ? bus.b_ack : bus.a_ack;
         ack_o = port ? bus.a_ack : bus.b_ack;
         rd_p  = port ? bus.b_rdata : bus.a_rdata;
         rd_o  = port ? bus.a_rdata : bus.b_rdata;
         n_vec++;
         if (ack_p !== (c == RL + 2) || ack_o !== 1'b0 ||
             bus.XI_PRdFinished !== (c == RL + 2) || bus.XI_PWr !== 1'b0) begin
            n_err++;
            $display("FAIL rd_strobes port %0d cycle %0d got ack=%b other_ack=%b fin=%b pwr=%b required ack=fin=%b",
                     port, c, ack_p, ack_o, bus.XI_PRdFinished, bus.XI_PWr, c == RL + 2);
         end
         if (c >= 1) begin
            n_vec++;
            if (bus.XI_PRWA !== addr || bus.XI_PRdSubA !== suba) begin
               n_err++;
               $display("FAIL rd_addr_hold cycle %0d got addr=%h suba=%h required addr=%h suba=%h",
                        c, bus.XI_PRWA, bus.XI_PRdSubA, addr, suba);
            end
         end
         n_vec++;
         if (rd_o !== exp_rdata[~port]) begin
            n_err++;
            $display("FAIL rd_other_hold cycle %0d got %h required %h", c, rd_o, exp_rdata[~port]);
         end
         if (ack_p === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL rd_ack_unexpected port %0d got ack with empty queue required none", port);
            end else begin
               e = sb.pop_front();
               if (rd_p !== e.data || e.port !== port) begin
                  n_err++;
                  $display("FAIL rd_data port %0d got %h required %h", port, rd_p, e.data);
               end
               exp_rdata[port] = e.data;
               $display("txn %s read addr=%h suba=%h data=%h", port ? "B" : "A", addr, suba, rd_p);
            end
         end else begin
            n_vec++;
            if (rd_p !== exp_rdata[port]) begin
               n_err++;
               $display("FAIL rd_own_hold cycle %0d got %h required %h", c, rd_p, exp_rdata[port]);
            end
         end
         @(posedge xclk); #1;
         if (c == RL + 2) begin
            if (port) bus.b_req = 1'b0; else bus.a_req = 1'b0;
         end
      end
   endtask

   task automatic test_read_scratch();
      do_read(1'b0, R_ID, SUBA_SCR);
   endtask

   task automatic test_read_id();
      do_read(1'b0, R_ID, SUBA_ID);
   endtask

   task automatic test_read_b();
      do_read(1'b1, 8'h47, 4'h9);
   endtask

   task automatic test_tie();
      logic       exp_port [4];
      exp_t       e;
      logic       p;
      logic [7:0] rd;
      int         acks = 0;
      int         last_c = 0;
      int         exp_c;
      bit         done = 0;
`ifdef PIFARB_RR_EN
      exp_port = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
      exp_port = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
      for (int i = 0; i < 4; i++) begin
         e.port = exp_port[i];
         e.data = exp_port[i] ? pif_read(8'h62, 4'h2, exp_scratch)
                              : pif_read(8'h21, 4'h1, exp_scratch);
         sb.push_back(e);
      end
      bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 8'h21; bus.a_suba = 4'h1;
      bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 8'h62; bus.b_suba = 4'h2;
      for (int c = 0; c < 4 * (RL + 3) + 6 && !done; c++) begin
         @(negedge xclk);
         n_vec++;
         if (bus.a_ack === 1'b1 && bus.b_ack === 1'b1) begin
            n_err++;
            $display("FAIL tie_dual_ack cycle %0d got both acks required at most one", c);
         end
         if (bus.a_ack === 1'b1 || bus.b_ack === 1'b1) begin
            p  = bus.b_ack;
            rd = p ? bus.b_rdata : bus.a_rdata;
            n_vec++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL tie_ack_unexpected got ack on port %0d required none", p);
            end else begin
               e = sb.pop_front();
               if (p !== e.port || rd !== e.data) begin
                  n_err++;
                  $display("FAIL tie_grant %0d got port=%0d data=%h required port=%0d data=%h",
                           acks, p, rd, e.port, e.data);
               end
               exp_rdata[e.port] = e.data;
            end
            exp_c = (acks == 0) ? RL + 2 : last_c + RL + 3;
            n_vec++;
            if (c != exp_c) begin
               n_err++;
               $display("FAIL tie_timing %0d got cycle %0d required %0d", acks, c, exp_c);
            end
            $display("txn tie grant %0d port %s data=%h", acks, p ? "B" : "A", rd);
            last_c = c;
            acks++;
         end
         @(posedge xclk); #1;
         if (acks == 4) begin
            bus.a_req = 1'b0;
            bus.b_req = 1'b0;
            done = 1;
         end
      end
      n_vec++;
      if (acks != 4 || sb.size() != 0) begin
         n_err++;
         $display("FAIL tie_count got %0d acks, %0d pending required 4 acks, 0 pending", acks, sb.size());
      end
      sb.delete();
      bus.a_req = 1'b0;
      bus.b_req = 1'b0;
   endtask

   task automatic test_b_drop();
      bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 8'h22; bus.b_wdata = 8'h5D;
      for (int c = 0; c <= 3; c++) begin
         @(negedge xclk);
         n_vec++;
         if (bus.XI_PWr !== (c == 1) || bus.b_ack !== (c == 2) || bus.a_ack !== 1'b0) begin
            n_err++;
            $display("FAIL wr_b_drop cycle %0d got pwr=%b b_ack=%b a_ack=%b required pwr=%b b_ack=%b a_ack=0",
                     c, bus.XI_PWr, bus.b_ack, bus.a_ack, c == 1, c == 2);
         end
         if (c == 1) begin
            n_vec++;
            if (bus.XI_PD !== 8'h5D || bus.XI_PRWA !== 8'h22) begin
               n_err++;
               $display("FAIL wr_b_bus got addr=%h data=%h required addr=22 data=5d",
                        bus.XI_PRWA, bus.XI_PD);
            end
         end
         @(posedge xclk); #1;
         if (c == 0) bus.b_req = 1'b0;
      end
      $display("txn B write addr=22 data=5d (req dropped in cycle 1)");
   endtask

   task automatic test_reset_mid();
      bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 8'h33; bus.a_suba = 4'h5;
      repeat (3) begin
         @(posedge xclk); #1;
      end
      #2 sys_rst = 1'b0;
      #1;
      n_vec++;
      if ({bus.a_ack, bus.b_ack, bus.XI_PWr, bus.XI_PRdFinished, bus.XI_PRWA,
           bus.XI_PRdSubA, bus.XI_PD, bus.a_rdata, bus.b_rdata} !== '0) begin
         n_err++;
         $display("FAIL midrst_async got prwa=%h suba=%h a_rdata=%h b_rdata=%h required all 0",
                  bus.XI_PRWA, bus.XI_PRdSubA, bus.a_rdata, bus.b_rdata);
      end
      bus.a_req = 1'b0;
      exp_rdata[0] = 8'h00;
      exp_rdata[1] = 8'h00;
      for (int c = 0; c < 3; c++) begin
         @(negedge xclk);
         n_vec++;
         if ({bus.a_ack, bus.b_ack, bus.XI_PWr, bus.XI_PRdFinished} !== 4'b0000 ||
             bus.XI_PRWA !== 8'h00) begin
            n_err++;
            $display("FAIL midrst_quiet cycle %0d got acks=%b%b pwr=%b fin=%b prwa=%h required 0",
                     c, bus.a_ack, bus.b_ack, bus.XI_PWr, bus.XI_PRdFinished, bus.XI_PRWA);
         end
         @(posedge xclk); #1;
         if (c == 1) sys_rst = 1'b1;
      end
      $display("txn A read addr=33 discarded by reset");
      do_read(1'b0, R_ID, SUBA_ID);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired before completion");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      test_reset();
      test_write();
      test_read_scratch();
      test_read_id();
      test_read_b();
      test_tie();
      test_b_drop();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
